// File: rtl/vc_wb_buffer_if.sv
// Handshake/bus bundle for the dirty-line writeback buffer.
// Latency: none (wires only).
// Backpressure: wb_full toward the victim cache, pmem_resp from the memory adapter.
//
// Ports grouped here:
//   push side   : wb_push, wb_addr, wb_data -> wb_full
//   lookup side : lookup_addr -> lookup_hit, lookup_rdata
//   drain side  : flush, pmem_read_pending, pmem_resp -> pmem_write, pmem_address, pmem_wdata
//   status      : empty
interface vc_wb_buffer_if;
  logic         wb_push;
  logic [31:0]  wb_addr;
  logic [255:0] wb_data;
  logic         wb_full;
  logic [31:0]  lookup_addr;
  logic         lookup_hit;
  logic [255:0] lookup_rdata;
  logic         flush;
  logic         pmem_read_pending;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic         empty;

  // Driven by the victim cache / miss path / memory adapter side.
  modport master (
    output wb_push, wb_addr, wb_data, lookup_addr, flush, pmem_read_pending, pmem_resp,
    input  wb_full, lookup_hit, lookup_rdata, pmem_write, pmem_address, pmem_wdata, empty
  );

  // The buffer itself.
  modport slave (
    input  wb_push, wb_addr, wb_data, lookup_addr, flush, pmem_read_pending, pmem_resp,
    output wb_full, lookup_hit, lookup_rdata, pmem_write, pmem_address, pmem_wdata, empty
  );
endinterface

// File: rtl/vc_wb_buffer.sv
// Dirty-line writeback buffer between victim cache and cacheline adapter, with coalescing.
// Latency: push visible to lookup/count next cycle; pmem_write rises one cycle after drain condition.
// Backpressure: wb_full (count==DEPTH) drops pushes unless the head pops that same cycle.
//
// Ports: clk, rst (synchronous, active low), bus (vc_wb_buffer_if.slave).
// Optional feature: define VC_WB_FORWARD_EN to compile in lookup forwarding;
// without it lookup_hit/lookup_rdata are tied to 0.
module vc_wb_buffer #(
  parameter int DEPTH      = 4,
  parameter int HIGH_WATER = 3,
  parameter int IDLE_LIMIT = 8
) (
  input logic          clk,
  input logic          rst,
  vc_wb_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(IDLE_LIMIT + 1);

  typedef struct packed {
    logic [26:0]  tag;   // line address bits [31:5]
    logic [255:0] data;
  } entry_t;

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t           state_q, state_d;
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic [TMR_W-1:0] timer_q;

  logic             full;
  logic             pop;
  logic             accept;
  logic             alloc;
  logic             co_hit;
  logic [PTR_W-1:0] co_idx;
  logic [PTR_W-1:0] co_scan;
  logic [PTR_W-1:0] wr_idx;
  logic [26:0]      push_tag;
  logic             drain_req;

  assign push_tag = bus.wb_addr[31:5];
  assign full     = (count_q == CNT_W'(DEPTH));
  assign pop      = (state_q == S_WRITE) && bus.pmem_resp;
  // A pop in the same cycle frees the head slot, so a full buffer still accepts.
  assign accept   = bus.wb_push && (!full || pop);
  assign alloc    = accept && !co_hit;
  assign wr_idx   = alloc ? tail_q : co_idx;

  assign bus.wb_full = full;
  assign bus.empty   = (count_q == '0);

  // Coalesce target: youngest valid entry with the same line address. The head
  // is excluded while it is being written so the in-flight data stays stable.
  always_comb begin
    co_hit  = 1'b0;
    co_idx  = '0;
    co_scan = '0;
    for (int k = 0; k < DEPTH; k++) begin
      co_scan = head_q + PTR_W'(k);
      if (CNT_W'(k) < count_q && mem[co_scan].tag == push_tag &&
          !(k == 0 && state_q == S_WRITE)) begin
        co_hit = 1'b1;
        co_idx = co_scan;
      end
    end
  end

`ifdef VC_WB_FORWARD_EN
  logic             lk_hit;
  logic [PTR_W-1:0] lk_idx;
  logic [PTR_W-1:0] lk_scan;
  logic             unused_addr_lsbs;

  // Later (younger) matches overwrite earlier ones, so the youngest copy wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_idx  = '0;
    lk_scan = '0;
    for (int k = 0; k < DEPTH; k++) begin
      lk_scan = head_q + PTR_W'(k);
      if (CNT_W'(k) < count_q && mem[lk_scan].tag == bus.lookup_addr[31:5]) begin
        lk_hit = 1'b1;
        lk_idx = lk_scan;
      end
    end
  end

  assign bus.lookup_hit   = lk_hit;
  assign bus.lookup_rdata = lk_hit ? mem[lk_idx].data : '0;
  assign unused_addr_lsbs = ^{bus.wb_addr[4:0], bus.lookup_addr[4:0]};
`else
  logic unused_addr_lsbs;

  assign bus.lookup_hit   = 1'b0;
  assign bus.lookup_rdata = '0;
  assign unused_addr_lsbs = ^{bus.wb_addr[4:0], bus.lookup_addr};
`endif

  // Entry storage: contents are only meaningful within [head, head+count).
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_idx].tag  <= push_tag;
      mem[wr_idx].data <= bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      if (pop)   head_q <= head_q + PTR_W'(1);
      if (alloc) tail_q <= tail_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(alloc) - CNT_W'(pop);
      if (accept)
        timer_q <= '0;
      else if (count_q != '0 && timer_q != TMR_W'(IDLE_LIMIT))
        timer_q <= timer_q + TMR_W'(1);
    end
  end

  assign drain_req = (count_q >= CNT_W'(HIGH_WATER)) || bus.flush ||
                     (timer_q == TMR_W'(IDLE_LIMIT));

  // Next state and drain outputs. A pop always returns to IDLE, which gives
  // the mandatory idle cycle between consecutive writes.
  always_comb begin
    state_d          = state_q;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0 && !bus.pmem_read_pending && drain_req)
          state_d = S_WRITE;
      end
      S_WRITE: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {mem[head_q].tag, 5'b0};
        bus.pmem_wdata   = mem[head_q].data;
        if (bus.pmem_resp)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vc_wb_buffer.sv
// Bench for vc_wb_buffer: directed pushes/drains with a scoreboard of expected memory writes.
// Latency: n/a.
// Backpressure: bench acts as victim cache and memory adapter.
module tb_vc_wb_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vc_wb_buffer_if bus();

  vc_wb_buffer #(.DEPTH(4), .HIGH_WATER(3), .IDLE_LIMIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef VC_WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] data;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  wr_t  stim_e;
  int   checks   = 0;
  int   failures = 0;
  logic pw_prev  = 1'b0;

  logic [255:0] dat_a, dat_b, dat_c, dat_e, dat_f;
  logic [255:0] dat_l [5];

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Scoreboard monitor: every new memory write is matched against the queue.
  always @(negedge clk) begin
    if (bus.pmem_write && !pw_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %h, expected no write", bus.pmem_address);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", {224'b0, bus.pmem_address}, {224'b0, mon_e.addr});
        chk("wr_data", bus.pmem_wdata, mon_e.data);
      end
    end
    pw_prev = bus.pmem_write;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [255:0] d);
    stim_e.addr = a;
    stim_e.data = d;
    exp_q.push_back(stim_e);
  endtask

  task automatic push(input logic [31:0] a, input logic [255:0] d);
    bus.wb_push = 1'b1;
    bus.wb_addr = a;
    bus.wb_data = d;
    tick();
    bus.wb_push = 1'b0;
  endtask

  task automatic wait_write(output int n);
    n = 0;
    while (!bus.pmem_write && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic respond();
    bus.pmem_resp = 1'b1;
    tick();
    bus.pmem_resp = 1'b0;
  endtask

  task automatic drain_one(input string name);
    int n;
    wait_write(n);
    chk({name, "_write_seen"}, bus.pmem_write, 1);
    respond();
    chk({name, "_idle_gap"}, bus.pmem_write, 0);
  endtask

  task automatic look(input logic [31:0] a);
    bus.lookup_addr = a;
    #1;
  endtask

  initial begin
    int n;
    dat_a = {8{32'hAAAA_0001}};
    dat_b = {8{32'hBBBB_0002}};
    dat_c = {8{32'hCCCC_0003}};
    dat_e = {8{32'hEEEE_0004}};
    dat_f = {8{32'hFFFF_0005}};
    for (int i = 0; i < 5; i++) dat_l[i] = {8{32'h1000_0000 + 32'(i)}};

    bus.wb_push = 1'b0;
    bus.wb_addr = '0;
    bus.wb_data = '0;
    bus.lookup_addr = '0;
    bus.flush = 1'b0;
    bus.pmem_read_pending = 1'b0;
    bus.pmem_resp = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_pmem_write", bus.pmem_write, 0);
    chk("rst_pmem_address", {224'b0, bus.pmem_address}, 0);
    chk("rst_pmem_wdata", bus.pmem_wdata, 0);
    chk("rst_wb_full", bus.wb_full, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_lookup_hit", bus.lookup_hit, 0);
    chk("rst_lookup_rdata", bus.lookup_rdata, 0);
    rst = 1'b1;
    tick();

    // Single line: lookup with offset bits, idle-timer drain after 9 edges
    expect_wr(32'h100, dat_a);
    push(32'h100, dat_a);
    look(32'h104);
    chk("t1_lookup_hit", bus.lookup_hit, FWD);
    chk("t1_lookup_rdata", bus.lookup_rdata, FWD ? dat_a : 256'b0);
    chk("t1_empty", bus.empty, 0);
    chk("t1_full", bus.wb_full, 0);
    wait_write(n);
    chk("t1_timer_drain_cycles", 256'(n), 9);
    respond();
    chk("t1_write_done", bus.pmem_write, 0);
    chk("t1_empty_after", bus.empty, 1);
    chk("t1_lookup_gone", bus.lookup_hit, 0);

    // Same-address pushes coalesce
    expect_wr(32'h100, dat_b);
    push(32'h100, dat_a);
    push(32'h11F, dat_b);
    look(32'h100);
    chk("t2_lookup_rdata", bus.lookup_rdata, FWD ? dat_b : 256'b0);
    bus.flush = 1'b1;
    drain_one("t2");
    bus.flush = 1'b0;
    chk("t2_single_entry", bus.empty, 1);

    // Fill while reads pending; overflow dropped; stray resp ignored
    bus.pmem_read_pending = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_wr(32'h1000 * (i + 1), dat_l[i]);
      push(32'h1000 * (i + 1), dat_l[i]);
    end
    tick();
    tick();
    chk("t3_blocked_by_read", bus.pmem_write, 0);
    expect_wr(32'h4000, dat_l[3]);
    push(32'h4000, dat_l[3]);
    chk("t3_full", bus.wb_full, 1);
    push(32'h5000, dat_l[4]);
    chk("t3_full_after_drop", bus.wb_full, 1);
    look(32'h5000);
    chk("t3_dropped_miss", bus.lookup_hit, 0);
    look(32'h3008);
    chk("t3_lookup_hit", bus.lookup_hit, FWD);
    chk("t3_lookup_rdata", bus.lookup_rdata, FWD ? dat_l[2] : 256'b0);
    respond();
    chk("t3_stray_resp_full", bus.wb_full, 1);
    chk("t3_stray_resp_no_write", bus.pmem_write, 0);
    bus.pmem_read_pending = 1'b0;
    tick();
    chk("t3_write_after_release", bus.pmem_write, 1);
    bus.flush = 1'b1;
    for (int i = 0; i < 4; i++) drain_one("t3");
    bus.flush = 1'b0;
    chk("t3_empty", bus.empty, 1);

    // Push matching the in-flight head allocates a new entry
    expect_wr(32'h200, dat_e);
    push(32'h200, dat_e);
    bus.flush = 1'b1;
    wait_write(n);
    bus.flush = 1'b0;
    chk("t4_writing", bus.pmem_write, 1);
    expect_wr(32'h200, dat_c);
    push(32'h200, dat_c);
    chk("t4_head_data_stable", bus.pmem_wdata, dat_e);
    look(32'h200);
    chk("t4_lookup_youngest", bus.lookup_rdata, FWD ? dat_c : 256'b0);
    respond();
    chk("t4_not_empty", bus.empty, 0);
    bus.flush = 1'b1;
    drain_one("t4");
    bus.flush = 1'b0;
    chk("t4_empty", bus.empty, 1);

    // Full buffer, push and pop in the same cycle, order kept across wrap
    bus.pmem_read_pending = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_wr(32'h10000 + 32'h1000 * i, dat_l[i]);
      push(32'h10000 + 32'h1000 * i, dat_l[i]);
    end
    chk("t5_full", bus.wb_full, 1);
    bus.pmem_read_pending = 1'b0;
    tick();
    chk("t5_writing", bus.pmem_write, 1);
    expect_wr(32'h14000, dat_l[4]);
    bus.wb_push = 1'b1;
    bus.wb_addr = 32'h14000;
    bus.wb_data = dat_l[4];
    bus.pmem_resp = 1'b1;
    tick();
    bus.wb_push = 1'b0;
    bus.pmem_resp = 1'b0;
    chk("t5_still_full", bus.wb_full, 1);
    chk("t5_popped", bus.pmem_write, 0);
    look(32'h14000);
    chk("t5_new_tail_hit", bus.lookup_hit, FWD);
    bus.flush = 1'b1;
    for (int i = 0; i < 4; i++) drain_one("t5");
    bus.flush = 1'b0;
    chk("t5_empty", bus.empty, 1);

    // Reset during a write drops it
    expect_wr(32'h300, dat_f);
    push(32'h300, dat_f);
    bus.flush = 1'b1;
    wait_write(n);
    bus.flush = 1'b0;
    chk("t6_writing", bus.pmem_write, 1);
    rst = 1'b0;
    tick();
    chk("t6_write_dropped", bus.pmem_write, 0);
    chk("t6_empty", bus.empty, 1);
    rst = 1'b1;
    tick();
    tick();
    chk("t6_no_write_after", bus.pmem_write, 0);

    chk("all_writes_seen", 256'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vc_wb_buffer.md
# vc_wb_buffer

Dirty-line writeback buffer that sits directly downstream of the victim cache and upstream of the physical-memory cacheline adapter. It accepts dirty 256-bit lines evicted from the victim cache, holds them in a small FIFO, and drains them to memory when the read path is idle. It also forwards buffered data to lookups so that a miss on a line awaiting writeback never reads stale memory. Same-address pushes coalesce in place.

## Interface
- DEPTH, 4: number of line entries (power of two, 2..16).
- HIGH_WATER, 3: occupancy at or above which draining is requested.
- IDLE_LIMIT, 8: cycles without a push after which a non-empty buffer drains.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-low reset.
- wb_push  in  1  victim cache presents a dirty line this cycle.
- wb_addr  in  32  line address; bits [4:0] ignored and stored as 0.
- wb_data  in  256  line data.
- wb_full  out  1  no free entry; `wb_push` while high is dropped.
- lookup_addr  in  32  address probed by the L1/victim miss path.
- lookup_hit  out  1  buffered copy of `lookup_addr` exists (combinational).
- lookup_rdata  out  256  buffered line for `lookup_hit`.
- flush  in  1  drain regardless of occupancy and idle timer.
- pmem_read_pending  in  1  a line fill is in flight at the adapter; blocks new writes.
- pmem_write  out  1  write request to the cacheline adapter.
- pmem_address  out  32  address of head entry, [4:0]=0.
- pmem_wdata  out  256  data of head entry.
- pmem_resp  in  1  adapter completed the write.
- empty  out  1  count==0.

## Operation
- Storage: circular FIFO, head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH, count of log2(DEPTH)+1 bits.
- Push with a valid non-head-in-flight entry whose address matches: overwrite that entry's data; count unchanged.
- Push with a match only on the head while state is WRITE: allocate a new tail entry. Head write completes with old data.
- Push otherwise: write at tail, tail+1, count+1. Push with `wb_full`=1: dropped, no state change.
- Lookup: compare against all valid entries; on multiple matches the youngest wins. No match: `lookup_hit`=0, `lookup_rdata`=0.
- Idle timer: resets to 0 on any accepted push. Otherwise increments while count>0, saturating at IDLE_LIMIT.
- FSM IDLE: go to WRITE when count>0 and !pmem_read_pending and (count>=HIGH_WATER or flush or timer==IDLE_LIMIT).
- FSM WRITE: `pmem_write`=1 and head fields driven stable. On `pmem_resp`: pop the head (head+1, count-1) and return to IDLE.
- `pmem_read_pending` rising during WRITE does not abort the write.
- Push and pop in the same cycle: count unchanged, both pointers advance. This is legal at count==DEPTH, and `wb_full` then remains 1 next cycle.

## Timing
- Reset: all outputs 0, count=0, pointers=0, timer=0, state IDLE; entry contents don't-care but invalid.
- Accepted push is visible to lookup and count on the next cycle; `wb_full` is registered from count.
- From the drain condition true in IDLE, `pmem_write` rises on the next cycle.
- After a pop, at least one IDLE cycle occurs before the next `pmem_write`.
- `pmem_resp` outside WRITE is ignored.
- Reset asserted mid-WRITE drops the transfer; `pmem_write` is low the cycle after reset is sampled.

## Configuration
- `VC_WB_FORWARD_EN` defined: lookup compare/mux compiled in as described.
- Not defined: `lookup_hit`=0 and `lookup_rdata`=0 always. Coalescing still uses the internal match. The system must then flush before any fill that may alias a buffered line.

## Test plan
- Reset, then push 0x100 with data A: next cycle `lookup_addr`=0x104 gives hit=1, rdata=A. count=1, timer reaches 8, `pmem_write` with address 0x100, `pmem_resp` clears `empty`→1.
- Push 0x100/A then 0x100/B: count stays 1 and drain writes B only.
- Push 4 distinct lines: `wb_full`=1. A 5th push is dropped, and a lookup of the 5th address misses.
- At count=3 with `pmem_read_pending`=1: no `pmem_write`. Deassert it, and `pmem_write` follows 1 cycle later.
- During WRITE of 0x200, push 0x200/C: new entry allocated, first write carries old data, second write carries C.
- Full buffer with push and `pmem_resp` in the same cycle: count stays 4, FIFO order preserved across pointer wrap.
